// File: rtl/cpu_pkg.sv
// Shared constants for the control unit: FSM states, opcodes, ALU codes.
// Instruction classes produced by opcode_decode also live here.
package cpu_pkg;

  typedef enum logic [2:0] {
    RST, T0, T1, T2, T3, T4, T5, HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE, CL_ITYPE, CL_IN, CL_OUT,
    CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_t;

  localparam int OP_ADD  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_AND  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_ADDI = 12;
  localparam int OP_ANDI = 13;
  localparam int OP_ORI  = 14;
  localparam int OP_IN   = 22;
  localparam int OP_OUT  = 23;
  localparam int OP_NOP  = 26;
  localparam int OP_HALT = 27;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;

endpackage

// File: rtl/opcode_decode.sv
// Maps an opcode to its instruction class and ALU operation code.
// Any opcode not listed decodes as CL_ILLEGAL.
module opcode_decode
  import cpu_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc,
  output op_class_t        cls,
  output logic [3:0]       alu
);

  always_comb begin
    cls = CL_ILLEGAL;
    alu = ALU_NONE;
    unique case (opc)
      OPC_W'(OP_ADD):  begin cls = CL_RTYPE; alu = ALU_ADD; end
      OPC_W'(OP_SUB):  begin cls = CL_RTYPE; alu = ALU_SUB; end
      OPC_W'(OP_AND):  begin cls = CL_RTYPE; alu = ALU_AND; end
      OPC_W'(OP_OR):   begin cls = CL_RTYPE; alu = ALU_OR;  end
      OPC_W'(OP_ADDI): begin cls = CL_ITYPE; alu = ALU_ADD; end
      OPC_W'(OP_ANDI): begin cls = CL_ITYPE; alu = ALU_AND; end
      OPC_W'(OP_ORI):  begin cls = CL_ITYPE; alu = ALU_OR;  end
      OPC_W'(OP_IN):   cls = CL_IN;
      OPC_W'(OP_OUT):  cls = CL_OUT;
      OPC_W'(OP_NOP):  cls = CL_NOP;
      OPC_W'(OP_HALT): cls = CL_HALT;
      default:         cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM; state register clocked on the falling edge.
// Define CONTROL_UNIT_STOP_EN to add the Stop (halt-after-instruction) input.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
`ifdef CONTROL_UNIT_STOP_EN
  input  logic        Stop,
`endif
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zlowin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPc,
  output logic        read,
  output logic        write,
  output logic [1:0]  mdr_read,
  output logic [3:0]  control,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        InPortout,
  output logic        OutPortin,
  output logic        Run,
  output logic        Illegal
);

  state_t    state, nxt;
  op_class_t cls;
  logic [3:0] alu;
  logic      armed;
  logic      stop_req;
  logic      ill_set;
  logic      unused_ir;

  assign unused_ir = ^IR[31-OPC_W:0];

`ifdef CONTROL_UNIT_STOP_EN
  assign stop_req = Stop;
`else
  assign stop_req = 1'b0;
`endif

  opcode_decode #(.OPC_W(OPC_W)) u_dec (
    .opc (IR[31:32-OPC_W]),
    .cls (cls),
    .alu (alu)
  );

  // armed delays the RST->T0 step by one falling edge after release
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state   <= RST;
      armed   <= 1'b0;
      Illegal <= 1'b0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
      if (ill_set) Illegal <= 1'b1;
    end
  end

  assign ill_set = (state == T2) && (cls == CL_ILLEGAL);

  always_comb begin
    nxt = state;
    unique case (state)
      RST: nxt = armed ? T0 : RST;
      T0:  nxt = T1;
      T1:  nxt = T2;
      T2: begin
        unique case (cls)
          CL_RTYPE, CL_ITYPE,
          CL_IN, CL_OUT: nxt = T3;
          CL_HALT:       nxt = HALT;
          default:       nxt = stop_req ? HALT : T0;
        endcase
      end
      T3: begin
        if (cls == CL_RTYPE || cls == CL_ITYPE) nxt = T4;
        else nxt = stop_req ? HALT : T0;
      end
      T4:   nxt = T5;
      T5:   nxt = stop_req ? HALT : T0;
      HALT: nxt = HALT;
      default: nxt = RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; Zlowin = 1'b0; PCin = 1'b0;
    MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    IncPc = 1'b0; read = 1'b0; write = 1'b0;
    mdr_read = 2'b00; control = ALU_NONE;
    GRA = 1'b0; GRB = 1'b0; GRC = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Cout = 1'b0; InPortout = 1'b0; OutPortin = 1'b0;
    Run = (state != HALT);
    unique case (state)
      T0: begin
        PCout = 1'b1; MARin = 1'b1;
        IncPc = 1'b1; Zlowin = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1; PCin = 1'b1;
        read = 1'b1; MDRin = 1'b1;
        mdr_read = 2'b01;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      T3: begin
        unique case (cls)
          CL_RTYPE: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_ITYPE: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_OUT: begin GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          CL_IN: begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        Zlowin = 1'b1;
        control = alu;
        if (cls == CL_RTYPE) begin
          GRC = 1'b1; Rout = 1'b1;
        end else begin
          Cout = 1'b1;
        end
      end
      T5: begin
        Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected per-cycle strobe vectors
// are queued when an instruction is applied and compared each cycle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR;
`ifdef CONTROL_UNIT_STOP_EN
  logic        Stop;
`endif
  logic PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin;
  logic Yin, IncPc, read, write;
  logic [1:0] mdr_read;
  logic [3:0] control;
  logic GRA, GRB, GRC, Rin, Rout, BAout, Cout, InPortout, OutPortin;
  logic Run, Illegal;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .IR(IR),
`ifdef CONTROL_UNIT_STOP_EN
    .Stop(Stop),
`endif
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin),
    .Zlowin(Zlowin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .IncPc(IncPc), .read(read), .write(write),
    .mdr_read(mdr_read), .control(control),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .InPortout(InPortout),
    .OutPortin(OutPortin), .Run(Run), .Illegal(Illegal)
  );

  typedef struct packed {
    logic PCout, Zlowout, MDRout, MARin, Zlowin, PCin;
    logic MDRin, IRin, Yin, IncPc, read, write;
    logic [1:0] mdr_read;
    logic GRA, GRB, GRC, Rin, Rout, BAout, Cout;
    logic InPortout, OutPortin, Run, Illegal;
    logic [3:0] control;
  } obs_t;

  typedef enum {
    P_RST, P_T0, P_T1, P_T2, P_R3, P_R4, P_R5,
    P_I3, P_I4, P_I5, P_O3, P_N3, P_HALT
  } ph_e;

  int   errors = 0;
  int   checks = 0;
  logic ill_exp = 1'b0;
  obs_t q[$];
  string tq[$];

  function automatic obs_t sample();
    obs_t s;
    s.PCout = PCout; s.Zlowout = Zlowout; s.MDRout = MDRout;
    s.MARin = MARin; s.Zlowin = Zlowin; s.PCin = PCin;
    s.MDRin = MDRin; s.IRin = IRin; s.Yin = Yin;
    s.IncPc = IncPc; s.read = read; s.write = write;
    s.mdr_read = mdr_read; s.GRA = GRA; s.GRB = GRB; s.GRC = GRC;
    s.Rin = Rin; s.Rout = Rout; s.BAout = BAout; s.Cout = Cout;
    s.InPortout = InPortout; s.OutPortin = OutPortin;
    s.Run = Run; s.Illegal = Illegal; s.control = control;
    return s;
  endfunction

  function automatic obs_t ex(ph_e p, logic [3:0] alu);
    obs_t e;
    e = '0;
    e.Run = (p != P_HALT);
    e.Illegal = ill_exp;
    case (p)
      P_T0: begin e.PCout = 1; e.MARin = 1; e.IncPc = 1; e.Zlowin = 1; end
      P_T1: begin
        e.Zlowout = 1; e.PCin = 1; e.read = 1; e.MDRin = 1;
        e.mdr_read = 2'b01;
      end
      P_T2: begin e.MDRout = 1; e.IRin = 1; end
      P_R3: begin e.GRB = 1; e.Rout = 1; e.Yin = 1; end
      P_R4: begin
        e.GRC = 1; e.Rout = 1; e.Zlowin = 1; e.control = alu;
      end
      P_I3: begin e.GRB = 1; e.BAout = 1; e.Yin = 1; end
      P_I4: begin e.Cout = 1; e.Zlowin = 1; e.control = alu; end
      P_R5, P_I5: begin e.Zlowout = 1; e.GRA = 1; e.Rin = 1; end
      P_O3: begin e.GRA = 1; e.Rout = 1; e.OutPortin = 1; end
      P_N3: begin e.InPortout = 1; e.GRA = 1; e.Rin = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] alu_of(int op);
    case (op)
      3, 12: return 4'd2;
      4:     return 4'd3;
      5, 13: return 4'd4;
      6, 14: return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  task automatic check(string tag, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(ph_e p, logic [3:0] alu, string tag);
    q.push_back(ex(p, alu));
    tq.push_back(tag);
  endtask

  task automatic drain();
    obs_t e;
    string t;
    while (q.size() > 0) begin
      @(posedge clk);
      e = q.pop_front();
      t = tq.pop_front();
      check(t, sample(), e);
    end
  endtask

  // expects the next falling edge to enter T0; returns after the last state
  task automatic do_instr(int op, string name);
    logic [3:0] a;
    a = alu_of(op);
    @(posedge clk);
    check({name, "_t0"}, sample(), ex(P_T0, 4'd0));
    #1 IR = {op[4:0], 27'($urandom)};
    push(P_T1, a, {name, "_t1"});
    push(P_T2, a, {name, "_t2"});
    case (op)
      3, 4, 5, 6: begin
        push(P_R3, a, {name, "_t3"});
        push(P_R4, a, {name, "_t4"});
        push(P_R5, a, {name, "_t5"});
      end
      12, 13, 14: begin
        push(P_I3, a, {name, "_t3"});
        push(P_I4, a, {name, "_t4"});
        push(P_I5, a, {name, "_t5"});
      end
      23: push(P_O3, a, {name, "_t3"});
      22: push(P_N3, a, {name, "_t3"});
      27: for (int i = 0; i < 10; i++) push(P_HALT, a, {name, "_halt"});
      default: ;
    endcase
    drain();
    if (!(op inside {3, 4, 5, 6, 12, 13, 14, 22, 23, 26, 27}))
      ill_exp = 1'b1;
  endtask

  // asserts reset just after a rising edge, checks it acts at once, releases
  task automatic hit_reset(string name);
    #1 reset = 1'b1;
    ill_exp = 1'b0;
    #1 check({name, "_async"}, sample(), ex(P_RST, 4'd0));
    @(posedge clk);
    #1 reset = 1'b0;
    push(P_RST, 4'd0, {name, "_hold"});
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    IR = '0;
`ifdef CONTROL_UNIT_STOP_EN
    Stop = 1'b0;
`endif
    repeat (2) @(posedge clk);
    check("reset", sample(), ex(P_RST, 4'd0));
    #1 reset = 1'b0;
    push(P_RST, 4'd0, "release");
    drain();

    do_instr(12, "addi");
    do_instr(4, "sub");
    do_instr(23, "out");
    do_instr(22, "in");
    do_instr(3, "add");
    do_instr(5, "and");
    do_instr(6, "or");
    do_instr(13, "andi");
    do_instr(14, "ori");
    do_instr(26, "nop");
    do_instr(27, "halt");
    hit_reset("halt_rst");

    do_instr(31, "ill");
    do_instr(26, "nop_ill");
    do_instr(12, "addi_ill");

    @(posedge clk);
    check("add4_t0", sample(), ex(P_T0, 4'd0));
    #1 IR = {5'd3, 27'($urandom)};
    push(P_T1, 4'd2, "add4_t1");
    push(P_T2, 4'd2, "add4_t2");
    push(P_R3, 4'd2, "add4_t3");
    push(P_R4, 4'd2, "add4_t4");
    drain();
    hit_reset("rst_t4");
    do_instr(4, "sub_post");

`ifdef CONTROL_UNIT_STOP_EN
    @(posedge clk);
    check("stop_t0", sample(), ex(P_T0, 4'd0));
    #1 IR = {5'd3, 27'($urandom)};
    push(P_T1, 4'd2, "stop_t1");
    push(P_T2, 4'd2, "stop_t2");
    drain();
    #1 Stop = 1'b1;
    push(P_R3, 4'd2, "stop_t3");
    push(P_R4, 4'd2, "stop_t4");
    push(P_R5, 4'd2, "stop_t5");
    push(P_HALT, 4'd0, "stop_halt");
    push(P_HALT, 4'd0, "stop_halt");
    drain();
    Stop = 1'b0;
    hit_reset("stop_rst");
    do_instr(23, "out_post");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
